// File: rtl/data_cache_controller_pkg.sv
// Shared widths, address-field positions and FSM encoding for the data cache controller
// and its tag array.
package data_cache_controller_pkg;

  localparam int ByteWidth             = 8;
  localparam int ByteSelectWidthInWord = 2;
  localparam int WordWidth             = ByteWidth * (1 << ByteSelectWidthInWord);
  localparam int AddressBusWidth       = 32;

  // Byte address = {tag, index, word select, byte select}.
  localparam int WordSelectWidth = 2;
  localparam int IndexWidth      = 4;
  localparam int OffsetWidth     = WordSelectWidth + ByteSelectWidthInWord;
  localparam int TagWidth        = AddressBusWidth - IndexWidth - OffsetWidth;
  localparam int IndexLsb        = OffsetWidth;
  localparam int TagLsb          = IndexLsb + IndexWidth;
  localparam int ArrayAddrWidth  = IndexWidth + OffsetWidth;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_DATA = 2'd1,
    ST_FILL      = 2'd2,
    ST_WRITE_MEM = 2'd3
  } state_e;

endpackage

// File: rtl/data_cache_controller_tag_array.sv
// Valid/tag store for the data cache: combinational lookup by index, written when a
// line fill completes, valid bits cleared asynchronously by reset.
module dcache_tag_array
  import data_cache_controller_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IndexWidth-1:0] index_i,
  output logic                  valid_o,
  output logic [TagWidth-1:0]   tag_o,
  input  logic                  wr_en_i,
  input  logic [TagWidth-1:0]   wr_tag_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TagWidth-1:0]  tag_q [NUM_LINES];

  assign valid_o = valid_q[index_i];
  assign tag_o   = tag_q[index_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  // NOTE: the tag storage has no reset; a tag is only trusted while its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[index_i] <= wr_tag_i;
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// Write-through, no-write-allocate data cache controller: tag lookup, line fill from main
// memory one word per handshake, and the control/address/data drive of the cache array.
module data_cache_controller
  import data_cache_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_CpuRequest,
  input  logic                      in_CpuRW,
  input  logic                      in_CpuBW,
  input  logic [ADDR_WIDTH-1:0]     in_CpuAddress,
  input  logic [WordWidth-1:0]      in_CpuWriteValue,
  output logic                      out_CpuAck,
  output logic [WordWidth-1:0]      out_CpuReadValue,
  output logic                      out_CacheMemoryAccessEnable,
  output logic                      out_CacheMemoryAccessRW,
  output logic                      out_CacheMemoryAccessBW,
  output logic [ArrayAddrWidth-1:0] out_CacheMemoryAccessAddress,
  output logic [WordWidth-1:0]      out_CacheMemoryWriteValue,
  input  logic [WordWidth-1:0]      in_CacheMemoryReadValue,
  output logic                      out_MemRequest,
  output logic                      out_MemRW,
  output logic                      out_MemBW,
  output logic [ADDR_WIDTH-1:0]     out_MemAddress,
  output logic [WordWidth-1:0]      out_MemWriteValue,
  input  logic                      in_MemReady,
  input  logic [WordWidth-1:0]      in_MemReadValue
);

  localparam logic [WordSelectWidth-1:0] LastWord = WordSelectWidth'(LINE_WORDS - 1);
  localparam logic [ByteSelectWidthInWord-1:0] ByteZero = '0;

  state_e                     state_q, state_d;
  logic [WordSelectWidth-1:0] cnt_q, cnt_d;
  logic [TagWidth-1:0]        req_tag, line_tag;
  logic [IndexWidth-1:0]      req_index;
  logic                       line_valid, hit, fill_done;

  assign req_tag   = in_CpuAddress[TagLsb +: TagWidth];
  assign req_index = in_CpuAddress[IndexLsb +: IndexWidth];
  assign hit       = line_valid && (line_tag == req_tag);

  dcache_tag_array #(
    .NUM_LINES(NUM_LINES)
  ) u_tags (
    .clk      (clock),
    .rst_n    (reset),
    .index_i  (req_index),
    .valid_o  (line_valid),
    .tag_o    (line_tag),
    .wr_en_i  (fill_done),
    .wr_tag_i (req_tag)
  );

  always_comb begin
    // NOTE: every output and next-state term gets a default first so no path infers a latch.
    state_d                      = state_q;
    cnt_d                        = cnt_q;
    fill_done                    = 1'b0;
    out_CpuAck                   = 1'b0;
    out_CpuReadValue             = '0;
    out_CacheMemoryAccessEnable  = 1'b0;
    out_CacheMemoryAccessRW      = 1'b0;
    out_CacheMemoryAccessBW      = 1'b0;
    out_CacheMemoryAccessAddress = '0;
    out_CacheMemoryWriteValue    = '0;
    out_MemRequest               = 1'b0;
    out_MemRW                    = 1'b0;
    out_MemBW                    = 1'b0;
    out_MemAddress               = '0;
    out_MemWriteValue            = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (in_CpuRequest) begin
          if (!in_CpuRW) begin
            state_d = ST_WRITE_MEM;
          end else if (hit) begin
            out_CacheMemoryAccessEnable  = 1'b1;
            out_CacheMemoryAccessRW      = 1'b1;
            out_CacheMemoryAccessBW      = in_CpuBW;
            out_CacheMemoryAccessAddress = in_CpuAddress[ArrayAddrWidth-1:0];
            state_d                      = ST_READ_DATA;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      // The array's read port is registered, so the data arrives one cycle after enable.
      ST_READ_DATA: begin
        out_CpuAck       = 1'b1;
        out_CpuReadValue = in_CacheMemoryReadValue;
        state_d          = ST_IDLE;
      end

      ST_FILL: begin
        out_MemRequest = 1'b1;
        out_MemRW      = 1'b1;
        out_MemAddress = {req_tag, req_index, cnt_q, ByteZero};
        if (in_MemReady) begin
          out_CacheMemoryAccessEnable  = 1'b1;
          out_CacheMemoryAccessAddress = {req_index, cnt_q, ByteZero};
          out_CacheMemoryWriteValue    = in_MemReadValue;
          cnt_d                        = cnt_q + 1'b1;
          if (cnt_q == LastWord) begin
            fill_done = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end

      // Write-through: memory always sees the store, the array only when the line is present.
      ST_WRITE_MEM: begin
        out_MemRequest    = 1'b1;
        out_MemBW         = in_CpuBW;
        out_MemAddress    = in_CpuAddress;
        out_MemWriteValue = in_CpuWriteValue;
        if (in_MemReady) begin
          out_CpuAck = 1'b1;
          state_d    = ST_IDLE;
          if (hit) begin
            out_CacheMemoryAccessEnable  = 1'b1;
            out_CacheMemoryAccessBW      = in_CpuBW;
            out_CacheMemoryAccessAddress = in_CpuAddress[ArrayAddrWidth-1:0];
            out_CacheMemoryWriteValue    = in_CpuWriteValue;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller: behavioural main memory and cache array,
// plus a line-level valid/tag reference model driving expected latency, data and traffic.
module tb_data_cache_controller;

  localparam int LW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_CpuRequest = 1'b0;
  logic        in_CpuRW = 1'b0;
  logic        in_CpuBW = 1'b0;
  logic [31:0] in_CpuAddress = '0;
  logic [31:0] in_CpuWriteValue = '0;
  logic        out_CpuAck;
  logic [31:0] out_CpuReadValue;
  logic        out_CacheMemoryAccessEnable, out_CacheMemoryAccessRW, out_CacheMemoryAccessBW;
  logic [7:0]  out_CacheMemoryAccessAddress;
  logic [31:0] out_CacheMemoryWriteValue;
  logic [31:0] in_CacheMemoryReadValue = '0;
  logic        out_MemRequest, out_MemRW, out_MemBW;
  logic [31:0] out_MemAddress, out_MemWriteValue;
  logic        in_MemReady = 1'b0;
  logic [31:0] in_MemReadValue = '0;

  data_cache_controller dut (
    .clock                        (clock),
    .reset                        (reset),
    .in_CpuRequest                (in_CpuRequest),
    .in_CpuRW                     (in_CpuRW),
    .in_CpuBW                     (in_CpuBW),
    .in_CpuAddress                (in_CpuAddress),
    .in_CpuWriteValue             (in_CpuWriteValue),
    .out_CpuAck                   (out_CpuAck),
    .out_CpuReadValue             (out_CpuReadValue),
    .out_CacheMemoryAccessEnable  (out_CacheMemoryAccessEnable),
    .out_CacheMemoryAccessRW      (out_CacheMemoryAccessRW),
    .out_CacheMemoryAccessBW      (out_CacheMemoryAccessBW),
    .out_CacheMemoryAccessAddress (out_CacheMemoryAccessAddress),
    .out_CacheMemoryWriteValue    (out_CacheMemoryWriteValue),
    .in_CacheMemoryReadValue      (in_CacheMemoryReadValue),
    .out_MemRequest               (out_MemRequest),
    .out_MemRW                    (out_MemRW),
    .out_MemBW                    (out_MemBW),
    .out_MemAddress               (out_MemAddress),
    .out_MemWriteValue            (out_MemWriteValue),
    .in_MemReady                  (in_MemReady),
    .in_MemReadValue              (in_MemReadValue)
  );

  always #5 clock = ~clock;

  logic [142:0] all_outs;
  assign all_outs = {out_CpuAck, out_CpuReadValue, out_CacheMemoryAccessEnable,
                     out_CacheMemoryAccessRW, out_CacheMemoryAccessBW,
                     out_CacheMemoryAccessAddress, out_CacheMemoryWriteValue,
                     out_MemRequest, out_MemRW, out_MemBW, out_MemAddress, out_MemWriteValue};

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic        bw;
    logic [31:0] data;
    int          cyc;
  } xfer_t;

  xfer_t       mem_log[$];
  xfer_t       arr_log[$];
  bit   [31:0] mem [bit [31:0]];
  logic [7:0]  arr [256];
  int          cyc = 0;
  int          mem_wait = 0;
  int          wait_cnt = 0;
  int          ack_cyc = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_data = '0;
  int          total = 0;
  int          bad = 0;

  // Line-level reference model of the tag store.
  bit          ref_valid [16];
  logic [23:0] ref_tag [16];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return mem.exists(wa) ? mem[wa] : (wa ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] a, logic bw);
    logic [31:0] w;
    w = mem_word(a);
    return bw ? {4{w[{a[1:0], 3'b000} +: 8]}} : w;
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    return ref_valid[a[7:4]] && (ref_tag[a[7:4]] == a[31:8]);
  endfunction

  function automatic int m_lat(logic rw, bit h, int w);
    if (!rw) return w + 2;
    return h ? 2 : LW * (w + 1) + 3;
  endfunction

  task automatic m_commit(input logic rw, input logic [31:0] a);
    if (rw && !m_hit(a)) begin
      ref_valid[a[7:4]] = 1'b1;
      ref_tag[a[7:4]]   = a[31:8];
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (rd_pend) begin
      rd_pend = 1'b0;
      #1 in_CacheMemoryReadValue = rd_data;
    end
  end

  // Main memory responder and cache array model; both sample the DUT mid-cycle.
  always @(negedge clock) begin
    if (reset && out_MemRequest) begin
      if (wait_cnt >= mem_wait) begin
        in_MemReady     = 1'b1;
        in_MemReadValue = mem_word(out_MemAddress);
      end else begin
        in_MemReady = 1'b0;
        wait_cnt++;
      end
    end else begin
      in_MemReady = 1'b0;
      wait_cnt    = 0;
    end
    #1;
    if (out_MemRequest && in_MemReady) begin
      mem_log.push_back('{out_MemAddress, out_MemRW, out_MemBW,
                          out_MemRW ? in_MemReadValue : out_MemWriteValue, cyc});
      if (!out_MemRW) begin
        logic [31:0] w;
        w = mem_word(out_MemAddress);
        if (out_MemBW) w[{out_MemAddress[1:0], 3'b000} +: 8] = out_MemWriteValue[7:0];
        else w = out_MemWriteValue;
        mem[{out_MemAddress[31:2], 2'b00}] = w;
      end
      wait_cnt = 0;
    end
    if (out_CacheMemoryAccessEnable) begin
      int b;
      b = int'({out_CacheMemoryAccessAddress[7:2], 2'b00});
      if (out_CacheMemoryAccessRW) begin
        rd_pend = 1'b1;
        rd_data = out_CacheMemoryAccessBW ? {4{arr[out_CacheMemoryAccessAddress]}}
                                          : {arr[b+3], arr[b+2], arr[b+1], arr[b]};
      end else begin
        arr_log.push_back('{{24'd0, out_CacheMemoryAccessAddress}, 1'b0,
                            out_CacheMemoryAccessBW, out_CacheMemoryWriteValue, cyc});
        if (out_CacheMemoryAccessBW) begin
          arr[out_CacheMemoryAccessAddress] = out_CacheMemoryWriteValue[7:0];
        end else begin
          for (int k = 0; k < 4; k++) arr[b+k] = out_CacheMemoryWriteValue[8*k +: 8];
        end
      end
    end
  end

  task automatic start_req(input logic rw, input logic bw, input logic [31:0] a,
                           input logic [31:0] wd);
    mem_log.delete();
    arr_log.delete();
    in_CpuRequest    = 1'b1;
    in_CpuRW         = rw;
    in_CpuBW         = bw;
    in_CpuAddress    = a;
    in_CpuWriteValue = wd;
  endtask

  // Latency counts cycles from the request cycle (1) to the ack cycle; -1 on timeout.
  task automatic wait_ack(output int lat, output logic [31:0] val);
    lat = 0;
    val = '0;
    while (lat < 300) begin
      @(negedge clock);
      #2;
      lat++;
      if (out_CpuAck === 1'b1) begin
        val     = out_CpuReadValue;
        ack_cyc = cyc;
        return;
      end
    end
    lat = -1;
  endtask

  task automatic end_req;
    @(posedge clock);
    #1;
    in_CpuRequest = 1'b0;
  endtask

  task automatic run_req(input logic rw, input logic bw, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] val);
    start_req(rw, bw, a, wd);
    wait_ack(lat, val);
    end_req();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    #2;
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    total++;
    if (dut.u_tags.valid_q !== 16'h0) begin
      bad++; $display("FAIL reset_valid: got %h expected 0000", dut.u_tags.valid_q);
    end
    in_CpuRequest = 1'b1; in_CpuRW = 1'b1; in_CpuAddress = 32'h104;
    #1;
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL reset_outputs_with_request: got %h expected 0", all_outs);
    end
    in_CpuRequest = 1'b0;
    @(negedge clock);
    #3 reset = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL idle_outputs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_read_miss;
    int          lat, exp_lat;
    logic [31:0] val;
    logic [31:0] words [LW];
    words = '{32'h0000_00A0, 32'hDDCC_BBAA, 32'h0000_00A8, 32'h0000_00AC};
    for (int k = 0; k < LW; k++) mem[32'h100 + 32'(4 * k)] = words[k];
    mem_wait = 0;
    exp_lat  = m_lat(1'b1, m_hit(32'h104), 0);
    run_req(1'b1, 1'b0, 32'h104, 32'h0, lat, val);
    total++;
    if (lat != exp_lat) begin
      bad++; $display("FAIL miss_latency: got %0d expected %0d", lat, exp_lat);
    end
    total++;
    if (val !== 32'hDDCC_BBAA) begin
      bad++; $display("FAIL miss_data: got %h expected ddccbbaa", val);
    end
    total++;
    if (mem_log.size() != LW || arr_log.size() != LW) begin
      bad++;
      $display("FAIL miss_traffic: got mem=%0d arr=%0d expected %0d each",
               mem_log.size(), arr_log.size(), LW);
    end else begin
      for (int k = 0; k < LW; k++) begin
        total++;
        if (mem_log[k].addr !== 32'h100 + 32'(4 * k) || mem_log[k].rw !== 1'b1 ||
            mem_log[k].bw !== 1'b0) begin
          bad++;
          $display("FAIL miss_mem_beat%0d: got addr=%h rw=%b bw=%b expected addr=%h rw=1 bw=0",
                   k, mem_log[k].addr, mem_log[k].rw, mem_log[k].bw, 32'h100 + 32'(4 * k));
        end
        total++;
        if (arr_log[k].addr !== 32'(4 * k) || arr_log[k].bw !== 1'b0 ||
            arr_log[k].data !== words[k]) begin
          bad++;
          $display("FAIL miss_arr_write%0d: got addr=%h bw=%b data=%h expected addr=%h bw=0 data=%h",
                   k, arr_log[k].addr, arr_log[k].bw, arr_log[k].data, 32'(4 * k), words[k]);
        end
      end
    end
    m_commit(1'b1, 32'h104);
    total++;
    if (dut.u_tags.valid_q[0] !== 1'b1 || dut.u_tags.tag_q[0] !== 24'h000001) begin
      bad++;
      $display("FAIL miss_tag_update: got valid=%b tag=%h expected valid=1 tag=000001",
               dut.u_tags.valid_q[0], dut.u_tags.tag_q[0]);
    end
  endtask

  // Word then byte hit issued back to back, each starting the cycle after the previous ack.
  task automatic test_read_hit;
    int          lat;
    logic [31:0] val;
    run_req(1'b1, 1'b0, 32'h104, 32'h0, lat, val);
    total++;
    if (lat != 2 || val !== 32'hDDCC_BBAA || mem_log.size() != 0) begin
      bad++;
      $display("FAIL hit_word: got lat=%0d data=%h beats=%0d expected lat=2 data=ddccbbaa beats=0",
               lat, val, mem_log.size());
    end
    run_req(1'b1, 1'b1, 32'h107, 32'h0, lat, val);
    total++;
    if (lat != 2 || val !== 32'hDDDD_DDDD || mem_log.size() != 0) begin
      bad++;
      $display("FAIL hit_byte: got lat=%0d data=%h beats=%0d expected lat=2 data=dddddddd beats=0",
               lat, val, mem_log.size());
    end
  endtask

  task automatic test_write_hit_wait;
    int          lat;
    logic [31:0] val;
    mem_wait = 3;
    run_req(1'b0, 1'b0, 32'h104, 32'h1234_5678, lat, val);
    total++;
    if (lat != m_lat(1'b0, 1'b1, 3)) begin
      bad++; $display("FAIL write_latency: got %0d expected %0d", lat, m_lat(1'b0, 1'b1, 3));
    end
    total++;
    if (mem_log.size() != 1 || arr_log.size() != 1) begin
      bad++;
      $display("FAIL write_traffic: got mem=%0d arr=%0d expected 1 each",
               mem_log.size(), arr_log.size());
    end else begin
      total++;
      if (mem_log[0].addr !== 32'h104 || mem_log[0].rw !== 1'b0 || mem_log[0].bw !== 1'b0 ||
          mem_log[0].data !== 32'h1234_5678) begin
        bad++;
        $display("FAIL write_mem_beat: got addr=%h rw=%b bw=%b data=%h expected 104/0/0/12345678",
                 mem_log[0].addr, mem_log[0].rw, mem_log[0].bw, mem_log[0].data);
      end
      total++;
      if (arr_log[0].addr !== 32'h04 || arr_log[0].bw !== 1'b0 ||
          arr_log[0].data !== 32'h1234_5678) begin
        bad++;
        $display("FAIL write_arr: got addr=%h bw=%b data=%h expected 04/0/12345678",
                 arr_log[0].addr, arr_log[0].bw, arr_log[0].data);
      end
      total++;
      if (arr_log[0].cyc != mem_log[0].cyc || mem_log[0].cyc != ack_cyc) begin
        bad++;
        $display("FAIL write_same_cycle: got arr=%0d mem=%0d ack=%0d expected all equal",
                 arr_log[0].cyc, mem_log[0].cyc, ack_cyc);
      end
    end
    mem_wait = 0;
    run_req(1'b1, 1'b0, 32'h104, 32'h0, lat, val);
    total++;
    if (lat != 2 || val !== 32'h1234_5678) begin
      bad++;
      $display("FAIL read_after_write: got lat=%0d data=%h expected lat=2 data=12345678", lat, val);
    end
  endtask

  task automatic test_write_miss_evict;
    int          lat;
    logic [31:0] val;
    mem_wait = 1;
    run_req(1'b0, 1'b0, 32'h2000, 32'hCAFE_F00D, lat, val);
    total++;
    if (lat != m_lat(1'b0, 1'b0, 1) || mem_log.size() != 1 || arr_log.size() != 0) begin
      bad++;
      $display("FAIL write_miss: got lat=%0d mem=%0d arr=%0d expected lat=%0d mem=1 arr=0",
               lat, mem_log.size(), arr_log.size(), m_lat(1'b0, 1'b0, 1));
    end
    total++;
    if (dut.u_tags.valid_q[0] !== 1'b1 || dut.u_tags.tag_q[0] !== ref_tag[0]) begin
      bad++;
      $display("FAIL write_miss_no_allocate: got valid=%b tag=%h expected valid=1 tag=%h",
               dut.u_tags.valid_q[0], dut.u_tags.tag_q[0], ref_tag[0]);
    end
    mem_wait = 0;
    run_req(1'b1, 1'b0, 32'h1104, 32'h0, lat, val);
    total++;
    if (lat != m_lat(1'b1, 1'b0, 0) || val !== mem_word(32'h1104)) begin
      bad++;
      $display("FAIL evict_fill: got lat=%0d data=%h expected lat=%0d data=%h",
               lat, val, m_lat(1'b1, 1'b0, 0), mem_word(32'h1104));
    end
    m_commit(1'b1, 32'h1104);
    total++;
    if (dut.u_tags.tag_q[0] !== 24'h000011) begin
      bad++; $display("FAIL evict_tag: got %h expected 000011", dut.u_tags.tag_q[0]);
    end
    run_req(1'b1, 1'b0, 32'h104, 32'h0, lat, val);
    total++;
    if (mem_log.size() != LW || val !== 32'h1234_5678) begin
      bad++;
      $display("FAIL refill_after_evict: got beats=%0d data=%h expected beats=%0d data=12345678",
               mem_log.size(), val, LW);
    end
    m_commit(1'b1, 32'h104);
  endtask

  task automatic test_random;
    int          lat, exp_lat, w, exp_beats, exp_arr;
    logic [31:0] a, wd, val, exp_val;
    logic        rw, bw;
    bit          h;
    for (int i = 0; i < 60; i++) begin
      a  = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom)};
      rw = 1'($urandom);
      bw = 1'($urandom);
      wd = $urandom;
      w  = $urandom_range(0, 2);
      mem_wait  = w;
      h         = m_hit(a);
      exp_lat   = m_lat(rw, h, w);
      exp_val   = m_load(a, bw);
      exp_beats = rw ? (h ? 0 : LW) : 1;
      exp_arr   = rw ? (h ? 0 : LW) : (h ? 1 : 0);
      run_req(rw, bw, a, wd, lat, val);
      total++;
      if (lat != exp_lat) begin
        bad++;
        $display("FAIL rand%0d_latency: addr=%h rw=%b got %0d expected %0d", i, a, rw, lat, exp_lat);
      end
      total++;
      if (mem_log.size() != exp_beats || arr_log.size() != exp_arr) begin
        bad++;
        $display("FAIL rand%0d_traffic: addr=%h rw=%b got mem=%0d arr=%0d expected mem=%0d arr=%0d",
                 i, a, rw, mem_log.size(), arr_log.size(), exp_beats, exp_arr);
      end
      if (rw) begin
        total++;
        if (val !== exp_val) begin
          bad++;
          $display("FAIL rand%0d_data: addr=%h bw=%b got %h expected %h", i, a, bw, val, exp_val);
        end
      end
      m_commit(rw, a);
    end
    mem_wait = 0;
  endtask

  task automatic test_reset_mid_fill;
    int          lat, n;
    logic [31:0] val;
    logic [31:0] a;
    a = 32'h3314;
    mem_wait = 0;
    start_req(1'b1, 1'b0, a, 32'h0);
    n = 0;
    while (mem_log.size() < 2 && n < 50) begin
      @(negedge clock);
      #2;
      n++;
    end
    total++;
    if (mem_log.size() != 2) begin
      bad++; $display("FAIL pre_reset_beats: got %0d expected 2", mem_log.size());
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) ref_valid[k] = 1'b0;
    #1;
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL mid_fill_reset_outputs: got %h expected 0", all_outs);
    end
    total++;
    if (dut.u_tags.valid_q[1] !== 1'b0) begin
      bad++; $display("FAIL mid_fill_reset_valid: got %b expected 0", dut.u_tags.valid_q[1]);
    end
    repeat (2) @(negedge clock);
    #3;
    mem_log.delete();
    reset = 1'b1;
    wait_ack(lat, val);
    end_req();
    total++;
    if (lat < 0 || mem_log.size() != LW || val !== mem_word(a)) begin
      bad++;
      $display("FAIL refill_after_reset: got lat=%0d beats=%0d data=%h expected beats=%0d data=%h",
               lat, mem_log.size(), val, LW, mem_word(a));
    end else begin
      total++;
      if (mem_log[0].addr !== 32'h3310) begin
        bad++; $display("FAIL refill_first_addr: got %h expected 00003310", mem_log[0].addr);
      end
    end
    m_commit(1'b1, a);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) arr[k] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      ref_valid[k] = 1'b0;
      ref_tag[k]   = '0;
    end
    #1 reset = 1'b0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit_wait();
    test_write_miss_evict();
    test_random();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
